// File: rtl/fifo_word_reader.sv
// fifo_word_reader: read-side consumer for the byte FIFO. Pops bytes while the
// FIFO is non-empty, packs WORD_BYTES of them little-endian into one word and
// offers that word downstream on a valid/ready handshake. A flush request
// emits a zero-padded partial word once the FIFO has drained.
module fifo_word_reader #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    rd_clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_data,
  output logic                    fifo_rd,
  input  logic                    flush,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [3:0]              word_len,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [CNT_W-1:0]        word_count
);

  localparam int unsigned BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t                          state_q,      state_d;
  logic [BC_W-1:0]                 byte_cnt_q,   byte_cnt_d;
  logic [WORD_BYTES-1:0][7:0]      lanes_q,      lanes_d;
  logic                            flush_pend_q, flush_pend_d;
  logic [3:0]                      word_len_q,   word_len_d;
  logic [CNT_W-1:0]                count_q,      count_d;

  // Lane n sits at bits [8n+7:8n]; lanes never shift, byte_cnt selects the slot.
  assign word_data  = lanes_q;
  assign word_len   = word_len_q;
  assign word_count = count_q;

  // Next-state, pop strobe and handshake outputs.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    lanes_d      = lanes_q;
    flush_pend_d = flush_pend_q | flush;
    word_len_d   = word_len_q;
    count_d      = count_q;
    fifo_rd      = 1'b0;
    word_valid   = 1'b0;

    case (state_q)
      FILL: begin
        if (!fifo_empty) begin
          // Pops take priority over a pending flush; the flush waits for drain.
          fifo_rd             = 1'b1;
          lanes_d[byte_cnt_q] = fifo_data;
          if (byte_cnt_q == BC_W'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            word_len_d = 4'(WORD_BYTES);
            state_d    = OUT;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (flush_pend_q) begin
          // A flush arriving in this same cycle re-arms the pending flag.
          flush_pend_d = flush;
          if (byte_cnt_q != '0) begin
            word_len_d = 4'(byte_cnt_q);
            state_d    = OUT;
          end
        end
      end

      OUT: begin
        word_valid = 1'b1;
        if (word_ready) begin
          count_d    = (count_q == '1) ? count_q : count_q + 1'b1;
          lanes_d    = '0;
          byte_cnt_d = '0;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // No pop is ever issued while reset is asserted.
    if (reset) begin
      fifo_rd = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q      <= FILL;
      byte_cnt_q   <= '0;
      lanes_q      <= '0;
      flush_pend_q <= 1'b0;
      word_len_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      lanes_q      <= lanes_d;
      flush_pend_q <= flush_pend_d;
      word_len_q   <= word_len_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench for fifo_word_reader: a queue models the show-ahead FIFO,
// expected words go into a scoreboard when bytes are queued and are compared
// when the DUT hands a word over.
module tb_fifo_word_reader;

  logic        rd_clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        flush;
  logic [31:0] word_data;
  logic [3:0]  word_len;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_count;

  fifo_word_reader #(.WORD_BYTES(4), .CNT_W(16)) dut (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .word_data  (word_data),
    .word_len   (word_len),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_count (word_count)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  len;
  } word_t;

  logic [7:0]  fifo_q[$];
  word_t       sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_count = '0;

  logic        obs_rd, obs_valid;
  logic [31:0] obs_data;
  logic [3:0]  obs_len;
  logic [15:0] obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    upd_fifo();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] l);
    word_t w;
    w.data = d;
    w.len  = l;
    sb.push_back(w);
  endtask

  // One clock: observe at negedge, apply the edge, then update the FIFO model.
  task automatic cyc();
    logic pop_s, acc_s, rst_s;
    word_t e;
    @(negedge rd_clk);
    obs_rd    = fifo_rd;
    obs_valid = word_valid;
    obs_data  = word_data;
    obs_len   = word_len;
    obs_cnt   = word_count;
    pop_s     = fifo_rd;
    acc_s     = word_valid && word_ready;
    rst_s     = reset;
    if (fifo_empty) check("pop_when_empty", fifo_rd, 0);
    if (acc_s && !rst_s) begin
      if (sb.size() == 0) begin
        check("unexpected_word", word_data, 0);
      end else begin
        e = sb.pop_front();
        check("word_data", word_data, e.data);
        check("word_len", word_len, e.len);
      end
    end
    @(posedge rd_clk);
    #1;
    if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
    if (rst_s) begin
      exp_count = '0;
    end else if (acc_s && exp_count != 16'hFFFF) begin
      exp_count = exp_count + 1'b1;
    end
    if (acc_s || rst_s) check("word_count", word_count, exp_count);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
      cyc();
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    word_ready = 1'b0;
    upd_fifo();

    // Reset held two cycles with a non-empty FIFO.
    push_byte(8'h10);
    push_byte(8'h20);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_rd", obs_rd, 0);
      check("rst_valid", obs_valid, 0);
      check("rst_cnt", obs_cnt, 0);
    end
    fifo_q.delete();
    upd_fifo();
    reset = 1'b0;
    cyc();
    check("idle_valid", obs_valid, 0);

    // Stream one full word.
    word_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    expect_word(32'h44332211, 4'd4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stream_pop", obs_rd, 1);
      check("stream_novalid", obs_valid, 0);
    end
    cyc();
    check("stream_valid", obs_valid, 1);
    check("stream_nopop", obs_rd, 0);
    check("stream_count", word_count, 1);

    // Backpressure with a full word pending and more data waiting.
    word_ready = 1'b0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    expect_word(32'hA4A3A2A1, 4'd4);
    for (int i = 0; i < 4; i++) cyc();
    push_byte(8'h55);
    expect_word(32'h00000055, 4'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_rd", obs_rd, 0);
      check("bp_valid", obs_valid, 1);
      check("bp_data", obs_data, 32'hA4A3A2A1);
      check("bp_len", obs_len, 4);
    end
    word_ready = 1'b1;
    cyc();
    cyc();
    check("after_bp_pop", obs_rd, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain(20);

    // Flush of a two-byte partial word, then a clean follow-up word.
    push_byte(8'hAA); push_byte(8'hBB);
    expect_word(32'h0000BBAA, 4'd2);
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain(20);
    push_byte(8'hCC);
    expect_word(32'h000000CC, 4'd1);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain(20);

    // Flush raised while six bytes are queued.
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    expect_word(32'h04030201, 4'd4);
    expect_word(32'h00000605, 4'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain(40);
    check("flush_data_count", word_count, 7);

    // Reset mid-word after three pops, then four new bytes.
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    for (int i = 0; i < 3; i++) cyc();
    push_byte(8'h99);
    reset = 1'b1;
    cyc();
    check("rst2_rd", obs_rd, 0);
    reset = 1'b0;
    check("rst2_cnt", word_count, 0);
    push_byte(8'h9A); push_byte(8'h9B); push_byte(8'h9C);
    expect_word(32'h9C9B9A99, 4'd4);
    drain(30);

    // Flush with nothing collected emits no word.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("flush_empty_novalid", obs_valid, 0);
    end
    check("final_count", word_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
